// File: rtl/if_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction fetch stage.
package if_pkg;

  localparam logic [63:0] PC_STEP          = 64'd4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'd0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries with flush; synchronous active-high reset.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'(Depth));
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guard the handshake locally so a misbehaving caller cannot corrupt the count.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// PC register plus 2-entry fetch buffer with valid/ready output and redirect flush.
// Define IF_ALIGN_CHECK_EN to trap misaligned redirects (sticky fetch_fault, halts fetch).
module instruction_fetch
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc,
  output logic        fetch_fault
);

  logic [63:0]  pc_q, pc_d;
  fetch_entry_t last_q, last_d;
  fetch_entry_t head, shown, wr_entry;
  logic         buf_full, buf_empty;
  logic         pop, push, flush, load_pc, halted;
  logic [63:0]  target;

`ifdef IF_ALIGN_CHECK_EN
  logic halted_q, halted_d;
  logic misaligned;

  assign misaligned  = (redirect_target[1:0] != 2'b00);
  assign halted      = halted_q;
  assign fetch_fault = halted_q;
  assign flush       = redirect_valid & ~halted_q;
  assign load_pc     = flush & ~misaligned;
  assign target      = redirect_target;
  assign halted_d    = halted_q | (flush & misaligned);

  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`else
  logic unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^redirect_target[1:0];
  assign halted          = 1'b0;
  assign fetch_fault     = 1'b0;
  assign flush           = redirect_valid;
  assign load_pc         = redirect_valid;
  assign target          = {redirect_target[63:2], 2'b00};
`endif

  assign pop      = out_valid & out_ready;
  assign push     = ~reset & ~redirect_valid & ~halted & (~buf_full | pop);
  assign wr_entry = '{pc: pc_q, instr: Instruction};

  fetch_fifo #(
    .Depth (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wr_entry),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .head_o  (head)
  );

  always_comb begin
    pc_d = pc_q;
    if (load_pc)   pc_d = target;
    else if (push) pc_d = pc_q + PC_STEP;
  end

  // Outputs keep showing the last valid head while the buffer is empty.
  assign shown  = buf_empty ? last_q : head;
  assign last_d = shown;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      last_q <= '0;
    end else begin
      pc_q   <= pc_d;
      last_q <= last_d;
    end
  end

  assign Inst_Address    = pc_q;
  assign out_valid       = ~buf_empty;
  assign out_pc          = shown.pc;
  assign out_instruction = shown.instr;

endmodule
